// File: rtl/knight_pkg.sv
// Shared Knight's Tour link definitions: command opcodes, headings, sequencer states
// and small helpers used by the command sequencer.
package knight_pkg;

  localparam logic [15:0] CAL_GYRO = 16'h2000;
  localparam logic [3:0]  MOVE     = 4'h4;
  localparam logic [3:0]  MOVE_FF  = 4'h5;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

  localparam logic [7:0] ACK_VAL_DEF = 8'hA5;

  typedef logic [2:0] seq_state_t;
  localparam seq_state_t S_IDLE      = 3'd0;
  localparam seq_state_t S_LOAD      = 3'd1;
  localparam seq_state_t S_SEND      = 3'd2;
  localparam seq_state_t S_WAIT_SNT  = 3'd3;
  localparam seq_state_t S_WAIT_RESP = 3'd4;
  localparam seq_state_t S_CHECK     = 3'd5;
  localparam seq_state_t S_DONE      = 3'd6;

  // Move command: opcode nibble, heading byte, square count nibble.
  function automatic logic [15:0] mk_move(input logic ff, input logic [7:0] hdg,
                                          input logic [3:0] sq);
    return {(ff ? MOVE_FF : MOVE), hdg, sq};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tour_cmd_sequencer_fifo.sv
// Show-ahead command FIFO: DEPTH x W, drops pushes when full, synchronous flush.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  // Flush wins over a same-cycle push so a halted sequence leaves the queue empty.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Command sequencer for the Knight's Tour remote link: queues commands, issues them
// one at a time to RemoteComm, waits for ack with timeout and bounded retries.
module tour_cmd_sequencer
  import knight_pkg::*;
#(
  parameter int         DEPTH        = 8,
  parameter int         TIMEOUT_CLKS = 5000000,
  parameter int         MAX_RETRY    = 2,
  parameter int         STOP_ON_ERR  = 1,
  parameter logic [7:0] ACK_VAL      = ACK_VAL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] cmd_in,
  input  logic        start,
  output logic        full,
  output logic        empty,
  output logic        snd_cmd,
  output logic [15:0] cmd,
  input  logic        cmd_snt,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  fail_cnt,
  output logic [7:0]  ok_cnt
);

  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam bit STOP = (STOP_ON_ERR != 0);

  seq_state_t    state;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] retry;
  logic          rsp_ok;
  logic          empty_done;
  logic [15:0]   head;
  logic          fail_now;
  logic          flush;

  assign fail_now = (state == S_CHECK) && !rsp_ok && (retry == RETRY_LAST);
  assign flush    = fail_now && STOP;

  cmd_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (state == S_LOAD),
    .flush   (flush),
    .wr_data (cmd_in),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign snd_cmd = (state == S_SEND);
  assign busy    = (state != S_IDLE);
  // A start on an empty queue finishes immediately without leaving IDLE.
  assign done    = (state == S_DONE) || empty_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd        <= '0;
      tmo_cnt    <= '0;
      retry      <= '0;
      rsp_ok     <= 1'b0;
      empty_done <= 1'b0;
      err        <= 1'b0;
      fail_cnt   <= '0;
      ok_cnt     <= '0;
    end else begin
      empty_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !empty) begin
            state    <= S_LOAD;
            err      <= 1'b0;
            fail_cnt <= '0;
            ok_cnt   <= '0;
            retry    <= '0;
          end else if (start) begin
            empty_done <= 1'b1;
          end
        end
        S_LOAD: begin
          cmd   <= head;
          retry <= '0;
          state <= S_SEND;
        end
        S_SEND: state <= S_WAIT_SNT;
        S_WAIT_SNT: begin
          if (cmd_snt) begin
            tmo_cnt <= '0;
            state   <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          // A response on the timeout clock is still honoured.
          if (resp_rdy) begin
            rsp_ok <= (resp == ACK_VAL);
            state  <= S_CHECK;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_ok <= 1'b0;
            state  <= S_CHECK;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_CHECK: begin
          if (rsp_ok) begin
            ok_cnt <= sat_inc8(ok_cnt);
            state  <= empty ? S_DONE : S_LOAD;
          end else if (retry != RETRY_LAST) begin
            retry <= retry + RW'(1);
            state <= S_SEND;
          end else begin
            err      <= 1'b1;
            fail_cnt <= sat_inc8(fail_cnt);
            state    <= (STOP || empty) ? S_DONE : S_LOAD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Bench for tour_cmd_sequencer: two instances (halt-on-error and continue-on-error)
// driven by a scripted RemoteComm responder and checked against a command-level model.
module tb_tour_cmd_sequencer;
  import knight_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;
  localparam int MR    = 2;
  localparam logic [7:0] ACK = 8'hA5;

  typedef struct {bit wh; logic [7:0] b; int dly;} rsp_t;
  typedef struct {bit push; logic [15:0] c; bit exp_full; bit exp_empty;} vec_t;
  typedef struct {int inst; logic [15:0] c; int t;} ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        push [2];
  logic [15:0] cmd_in [2];
  logic        start [2];
  logic        full [2], empty [2], snd_cmd [2], busy [2], done [2], err [2];
  logic [15:0] cmd [2];
  logic        cmd_snt [2], resp_rdy [2];
  logic [7:0]  resp [2];
  logic [7:0]  fail_cnt [2], ok_cnt [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rsp_t plan [64];
  int   plan_n = 0;
  int   plan_gen = 0;
  ev_t  log_q [$];
  int   snt_q [$];
  logic [15:0] got [$];
  int          gott [$];
  logic [15:0] exp_q [$];

  tour_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TMO), .MAX_RETRY(MR),
                       .STOP_ON_ERR(1), .ACK_VAL(ACK)) u0 (
    .clk(clk), .rst(rst), .push(push[0]), .cmd_in(cmd_in[0]), .start(start[0]),
    .full(full[0]), .empty(empty[0]), .snd_cmd(snd_cmd[0]), .cmd(cmd[0]),
    .cmd_snt(cmd_snt[0]), .resp_rdy(resp_rdy[0]), .resp(resp[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]), .fail_cnt(fail_cnt[0]), .ok_cnt(ok_cnt[0]));

  tour_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TMO), .MAX_RETRY(MR),
                       .STOP_ON_ERR(0), .ACK_VAL(ACK)) u1 (
    .clk(clk), .rst(rst), .push(push[1]), .cmd_in(cmd_in[1]), .start(start[1]),
    .full(full[1]), .empty(empty[1]), .snd_cmd(snd_cmd[1]), .cmd(cmd[1]),
    .cmd_snt(cmd_snt[1]), .resp_rdy(resp_rdy[1]), .resp(resp[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]), .fail_cnt(fail_cnt[1]), .ok_cnt(ok_cnt[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (snd_cmd[i] === 1'b1) log_q.push_back('{i, cmd[i], cyc});
  end

  // RemoteComm stand-in: one attempt consumes one plan entry; unplanned attempts are acked.
  initial begin
    rsp_t r;
    int pos, seen;
    pos = 0; seen = 0;
    for (int i = 0; i < 2; i++) begin
      cmd_snt[i] = 1'b0; resp_rdy[i] = 1'b0; resp[i] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (snd_cmd[i] === 1'b1) begin
          if (seen != plan_gen) begin pos = 0; seen = plan_gen; end
          if (pos < plan_n) r = plan[pos];
          else r = '{1'b0, ACK, 1};
          pos++;
          repeat (1 + $urandom_range(0, 2)) @(negedge clk);
          cmd_snt[i] = 1'b1; snt_q.push_back(cyc);
          @(negedge clk);
          cmd_snt[i] = 1'b0;
          if (!r.wh) begin
            repeat (r.dly) @(negedge clk);
            resp_rdy[i] = 1'b1; resp[i] = r.b;
            @(negedge clk);
            resp_rdy[i] = 1'b0; resp[i] = 8'h00;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_plan();
    plan_n = 0;
    plan_gen++;
  endtask

  task automatic add_plan(input bit wh, input logic [7:0] b, input int d);
    plan[plan_n] = '{wh, b, d};
    plan_n++;
  endtask

  task automatic push_cmd(input int i, input logic [15:0] c);
    push[i] = 1'b1; cmd_in[i] = c;
    @(negedge clk);
    push[i] = 1'b0;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (done[i] !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk("done_seen", 32'(done[i]), 32'd1);
  endtask

  task automatic collect(input int i, input int base);
    got.delete(); gott.delete();
    for (int k = base; k < log_q.size(); k++)
      if (log_q[k].inst == i) begin got.push_back(log_q[k].c); gott.push_back(log_q[k].t); end
  endtask

  task automatic chk_sent(input string nm);
    chk({nm, "_nsent"}, 32'(got.size()), 32'(exp_q.size()));
    if (got.size() == exp_q.size())
      foreach (exp_q[k]) chk({nm, "_cmd"}, 32'(got[k]), 32'(exp_q[k]));
  endtask

  task automatic chk_end(input string nm, input int i, input int okc, input int fc, input bit e);
    chk({nm, "_ok"}, 32'(ok_cnt[i]), 32'(okc));
    chk({nm, "_fail"}, 32'(fail_cnt[i]), 32'(fc));
    chk({nm, "_err"}, 32'(err[i]), 32'(e));
    chk({nm, "_empty"}, 32'(empty[i]), 32'd1);
  endtask

  // Command-level outcome: each command is tried until acked or MR re-sends are spent.
  task automatic model(input logic [15:0] cmds [$], input bit stop,
                       output int okc, output int fc, output bit e);
    int p = 0;
    bit halted = 0;
    exp_q.delete(); okc = 0; fc = 0; e = 0;
    foreach (cmds[k]) begin
      int tries = 0;
      bit fin = 0;
      if (halted) break;
      while (!fin) begin
        rsp_t r;
        exp_q.push_back(cmds[k]);
        r = (p < plan_n) ? plan[p] : '{1'b0, ACK, 1};
        p++;
        if (!r.wh && r.b == ACK) begin okc++; fin = 1; end
        else if (tries < MR) tries++;
        else begin fc++; e = 1; fin = 1; halted = stop; end
      end
    end
  endtask

  initial begin
    vec_t vec [9];
    logic [15:0] cq [$];
    int base, sbase, t0, okc, fc, n;
    bit e;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin push[i] = 1'b0; cmd_in[i] = '0; start[i] = 1'b0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_full", 32'(full[i]), 0);   chk("rst_empty", 32'(empty[i]), 1);
      chk("rst_snd", 32'(snd_cmd[i]), 0); chk("rst_cmd", 32'(cmd[i]), 0);
      chk("rst_busy", 32'(busy[i]), 0);   chk("rst_done", 32'(done[i]), 0);
      chk("rst_err", 32'(err[i]), 0);     chk("rst_fail", 32'(fail_cnt[i]), 0);
      chk("rst_ok", 32'(ok_cnt[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Nominal tour: calibrate, two moves, all acked; stray start mid-run ignored.
    clear_plan();
    push_cmd(0, CAL_GYRO); push_cmd(0, mk_move(1'b0, EAST, 4'd1)); push_cmd(0, mk_move(1'b1, SOUTH, 4'd2));
    base = log_q.size(); t0 = cyc;
    pulse_start(0);
    repeat (4) @(negedge clk);
    pulse_start(0);
    wait_done(0, 500);
    collect(0, base);
    exp_q = '{16'h2000, 16'h4BF1, 16'h57F2};
    chk_sent("nominal");
    if (gott.size() > 0) chk("start_latency", 32'(gott[0] - t0), 32'd2);
    chk_end("nominal", 0, 3, 0, 0);
    @(negedge clk);
    chk("idle_busy", 32'(busy[0]), 0);
    chk("idle_done", 32'(done[0]), 0);

    // NAK on the 2nd command, halt-on-error vs continue-on-error.
    for (int i = 0; i < 2; i++) begin
      clear_plan();
      add_plan(0, ACK, 2); add_plan(0, 8'h00, 1); add_plan(0, 8'h00, 3); add_plan(0, 8'h00, 0);
      push_cmd(i, 16'h2000); push_cmd(i, 16'h4BF1); push_cmd(i, 16'h57F2);
      base = log_q.size();
      pulse_start(i);
      wait_done(i, 1000);
      collect(i, base);
      if (i == 0) begin
        exp_q = '{16'h2000, 16'h4BF1, 16'h4BF1, 16'h4BF1};
        chk_sent("nak_stop"); chk_end("nak_stop", 0, 1, 1, 1);
      end else begin
        exp_q = '{16'h2000, 16'h4BF1, 16'h4BF1, 16'h4BF1, 16'h57F2};
        chk_sent("nak_cont"); chk_end("nak_cont", 1, 2, 1, 1);
      end
      @(negedge clk);
    end

    // Withheld response times out; the retry's response lands on the timeout clock.
    clear_plan();
    add_plan(1, 8'h00, 0); add_plan(0, ACK, TMO - 1);
    push_cmd(0, 16'h5000);
    base = log_q.size(); sbase = snt_q.size();
    pulse_start(0);
    wait_done(0, 1000);
    collect(0, base);
    exp_q = '{16'h5000, 16'h5000};
    chk_sent("tmo");
    if (gott.size() > 1 && snt_q.size() > sbase)
      chk("tmo_resend_gap", 32'(gott[1] - snt_q[sbase]), 32'(TMO + 2));
    chk_end("tmo", 0, 1, 0, 0);
    @(negedge clk);

    // FIFO fill: full after DEPTH pushes, extra push dropped.
    for (int k = 0; k < 9; k++) vec[k] = '{1'b1, 16'hA000 + 16'(k), (k >= DEPTH - 1), 1'b0};
    foreach (vec[k]) begin
      push_cmd(0, vec[k].c);
      chk("fill_full", 32'(full[0]), 32'(vec[k].exp_full));
      chk("fill_empty", 32'(empty[0]), 32'(vec[k].exp_empty));
    end
    clear_plan();
    base = log_q.size();
    pulse_start(0);
    wait_done(0, 1000);
    collect(0, base);
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(vec[k].c);
    chk_sent("fill"); chk_end("fill", 0, DEPTH, 0, 0);
    @(negedge clk);

    // Push coinciding with the LOAD pop keeps the occupancy unchanged.
    for (int k = 0; k < DEPTH - 1; k++) push_cmd(0, 16'hB000 + 16'(k));
    base = log_q.size();
    pulse_start(0);
    push_cmd(0, 16'hBEEF);
    chk("pushpop_full", 32'(full[0]), 0);
    chk("pushpop_empty", 32'(empty[0]), 0);
    wait_done(0, 1000);
    collect(0, base);
    exp_q.delete();
    for (int k = 0; k < DEPTH - 1; k++) exp_q.push_back(16'hB000 + 16'(k));
    exp_q.push_back(16'hBEEF);
    chk_sent("pushpop");
    @(negedge clk);

    // Reset while waiting for a response aborts everything.
    clear_plan();
    add_plan(0, ACK, 1); add_plan(1, 8'h00, 0);
    push_cmd(0, 16'h4001); push_cmd(0, 16'h4002); push_cmd(0, 16'h4003);
    pulse_start(0);
    n = 0;
    while (ok_cnt[0] != 8'd1 && n < 200) begin @(negedge clk); n++; end
    repeat (12) @(negedge clk);
    chk("prerst_busy", 32'(busy[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy[0]), 0); chk("midrst_empty", 32'(empty[0]), 1);
    chk("midrst_ok", 32'(ok_cnt[0]), 0); chk("midrst_fail", 32'(fail_cnt[0]), 0);
    chk("midrst_err", 32'(err[0]), 0);
    rst = 1'b0;
    base = log_q.size();
    repeat (300) @(negedge clk);
    collect(0, base);
    chk("midrst_nosend", 32'(got.size()), 0);

    // Randomized command lists and response scripts against the model.
    for (int it = 0; it < 12; it++) begin
      int inst = it % 2;
      int ncmd = $urandom_range(1, DEPTH);
      cq.delete();
      for (int k = 0; k < ncmd; k++)
        cq.push_back(mk_move(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 4'($urandom_range(1, 7))));
      clear_plan();
      for (int k = 0; k < ncmd * (MR + 1); k++) begin
        int x = $urandom_range(0, 9);
        logic [7:0] b = 8'($urandom_range(0, 255));
        if (b == ACK) b = 8'h00;
        if (x < 6) add_plan(0, ACK, $urandom_range(0, 5));
        else if (x < 9) add_plan(0, b, $urandom_range(0, 5));
        else add_plan(1, 8'h00, 0);
      end
      model(cq, inst == 0, okc, fc, e);
      foreach (cq[k]) push_cmd(inst, cq[k]);
      base = log_q.size();
      pulse_start(inst);
      wait_done(inst, ncmd * (MR + 1) * (TMO + 20) + 100);
      collect(inst, base);
      chk_sent("rand");
      chk_end("rand", inst, okc, fc, e);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
